axi_mem_window: RTL and testbench
=================================

Name: axi_mem_window

Overview:
- AXI4 address-window bridge between the Rocket memory master port and the Zynq HP/ACP slave port.
- Replaces the fixed upper-256 MB remap with a parametrised window: in-window requests are rebased and forwarded downstream.
- Out-of-window requests are never forwarded; the block terminates them locally with a DECERR response.
- Tracks outstanding downstream transactions so locally generated responses never interleave with downstream responses.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data width (strobe width is DATA_W/8).
- ID_W, 6, AXI ID width.
- IN_BASE, 32'h0000_0000, upstream window base; only bits [ADDR_W-1:WIN_BITS] are used.
- WIN_BASE, 32'h1000_0000, downstream DRAM base; only bits [ADDR_W-1:WIN_BITS] are used.
- WIN_BITS, 28, log2 of window size; must be ≥12.
- MAX_OUTST, 8, maximum outstanding downstream transactions per direction.

Ports:
- clock  in  1  single clock for the whole block.
- reset  in  1  synchronous, active-high.
- s_ar_*  in/out  valid, ready, addr[ADDR_W], id[ID_W], len[8], size[3], burst[2], cache, lock, prot, qos  upstream read address.
- s_r_*  out/in  valid, ready, data[DATA_W], id, resp[2], last  upstream read data.
- s_aw_*  in/out  same fields as s_ar_*  upstream write address.
- s_w_*  in/out  valid, ready, data, strb, last  upstream write data.
- s_b_*  out/in  valid, ready, id, resp  upstream write response.
- m_ar_*, m_r_*, m_aw_*, m_w_*, m_b_*  mirrored directions  downstream channels.
- cache, lock, prot, qos, size, burst, len and id pass through unmodified.

Behaviour:
- In-window test: addr[ADDR_W-1:WIN_BITS] == IN_BASE[ADDR_W-1:WIN_BITS].
- Remapped address: {WIN_BASE[ADDR_W-1:WIN_BITS], addr[WIN_BITS-1:0]}.
- No burst can cross the window edge, because AXI bursts stay within 4 KB and WIN_BITS ≥ 12.
- Read FSM states: R_IDLE, R_WAIT, R_ERR.
  - R_IDLE, in-window request: AR passes combinationally (m_ar_valid = s_ar_valid, s_ar_ready = m_ar_ready). It is blocked while rd_cnt == MAX_OUTST.
  - R_IDLE, out-of-window request: s_ar_ready = 1; latch id and len; go to R_WAIT.
  - R_WAIT: s_ar_ready = 0; m_r passes through; go to R_ERR when rd_cnt == 0.
  - R_ERR: drive s_r with data = 0, resp = 2'b11, id = latched id; m_r_ready = 0. Emit len+1 beats, with last asserted on the final beat. Return to R_IDLE on the last handshake.
  - rd_cnt increments on m_ar handshake and decrements on m_r handshake with last. Both events in the same cycle leave rd_cnt unchanged.
- Write FSM states: W_IDLE, W_PASS, W_DRAIN, W_ERRB.
  - W_IDLE, in-window AW: passes combinationally, blocked at wr_cnt == MAX_OUTST; handshake goes to W_PASS.
  - W_IDLE, out-of-window AW: accept it, latch id, go to W_DRAIN.
  - W_PASS: W passes through; m_w handshake with last returns to W_IDLE.
  - W_DRAIN: s_w_ready = 1 and nothing is forwarded; s_w handshake with last goes to W_ERRB.
  - W_ERRB: wait for wr_cnt == 0, then s_b_valid = 1 with resp = 2'b11 and the latched id; m_b_ready = 0. s_b handshake returns to W_IDLE.
  - s_aw_ready = 0 in every state except W_IDLE.
  - W beats arriving before AW are held (s_w_ready = 0 in W_IDLE).
  - wr_cnt increments on m_aw handshake and decrements on m_b handshake.
- Reset values: all valid outputs and all ready outputs 0; FSMs idle; counters 0; error registers 0.
- Reset mid-burst abandons the burst. System reset also resets the downstream port.

Optional Feature:
- Macro: AXI_WIN_STATS_EN.
- With it defined:
  - Output err_rd_cnt[32]: saturating count of DECERR reads, incremented on R_IDLE→R_WAIT.
  - Output err_wr_cnt[32]: saturating count of DECERR writes, incremented on W_IDLE→W_DRAIN.
  - Output last_err_addr[ADDR_W]: upstream address of the most recent rejected request. A simultaneous AR and AW rejection records the AR address.
- Without it: these ports and registers are absent, and behaviour is otherwise identical.

Decomposition:
- Package axi_win_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_DECERR = 2'b11.
  - rd_state_t and wr_state_t enums.
  - function win_hit(addr) and function win_remap(addr).
- Sub-module axi_win_outst_ctr is instantiated once per direction: inc, dec, count, full (count == MAX_OUTST), empty.

Test Plan:
- In-window read addr 0x0000_1000, len 3 -> m_ar_addr 0x1000_1000; 4 beats returned upstream unchanged with OKAY.
- Read addr 0x2000_0040, len 1, id 5 -> no m_ar_valid; 2 beats with data 0, resp 3, id 5, last on beat 2.
- Two in-window reads outstanding, then an out-of-window read -> error beats start only after both downstream last beats are delivered; no interleaving.
- Out-of-window write, len 7 -> 8 W beats sunk with m_w_valid = 0; then B with resp 3 and the AW id; wr_cnt stays 0.
- MAX_OUTST = 2 with three in-window AR and m_r stalled -> third s_ar_ready = 0 until one last beat completes.
- Assert reset during R_ERR beat 2 of 4 -> next cycle s_r_valid = 0, state R_IDLE; with AXI_WIN_STATS_EN, counters = 0.

Source files
------------

// File: rtl/axi_win_pkg.sv
// Shared types and helpers for the AXI memory-window bridge.
// Contents: response codes, read/write FSM state enums, window hit/remap functions.
// The helpers work on 64-bit addresses so any ADDR_W up to 64 can reuse them.
package axi_win_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_ERR} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_PASS, W_DRAIN, W_ERRB} wr_state_t;

  // True when addr and base agree on bits [addr_w-1:win_bits].
  function automatic logic win_hit(input logic [63:0] addr, input logic [63:0] base,
                                   input int win_bits, input int addr_w);
    logic [63:0] mask;
    // Shifting by 64 yields 0, and 0 - 1 is all ones, so addr_w == 64 is handled.
    mask = ((64'd1 << addr_w) - 64'd1) & ~((64'd1 << win_bits) - 64'd1);
    return ((addr ^ base) & mask) == 64'd0;
  endfunction

  // Upper bits from base, window offset from addr.
  function automatic logic [63:0] win_remap(input logic [63:0] addr, input logic [63:0] base,
                                            input int win_bits);
    logic [63:0] low;
    low = (64'd1 << win_bits) - 64'd1;
    return (base & ~low) | (addr & low);
  endfunction

endpackage

// File: rtl/axi_win_outst_ctr.sv
// Outstanding-transaction counter for one AXI direction.
// Ports: clock/reset, inc/dec events, count, full (count == MAX_OUTST), empty.
// Simultaneous inc and dec leave the count unchanged.
module axi_win_outst_ctr #(
  parameter int MAX_OUTST = 8,
  localparam int CW = $clog2(MAX_OUTST + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + 1'b1;
    end else if (dec && !inc) begin
      count <= count - 1'b1;
    end
  end

  assign full  = (count == CW'(MAX_OUTST));
  assign empty = (count == '0);

endmodule

// File: rtl/axi_mem_window.sv
// AXI4 window bridge: rebases in-window requests downstream, answers out-of-window ones with DECERR.
// Ports: clock/reset, upstream slave s_ar/s_r/s_aw/s_w/s_b, downstream master m_ar/m_r/m_aw/m_w/m_b.
// Optional AXI_WIN_STATS_EN adds err_rd_cnt, err_wr_cnt, last_err_addr.
module axi_mem_window
  import axi_win_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 6,
  parameter logic [ADDR_W-1:0] IN_BASE   = 32'h0000_0000,
  parameter logic [ADDR_W-1:0] WIN_BASE  = 32'h1000_0000,
  parameter int                WIN_BITS  = 28,
  parameter int                MAX_OUTST = 8
) (
  input  logic                clock,
  input  logic                reset,
`ifdef AXI_WIN_STATS_EN
  output logic [31:0]         err_rd_cnt,
  output logic [31:0]         err_wr_cnt,
  output logic [ADDR_W-1:0]   last_err_addr,
`endif
  input  logic                s_ar_valid,
  output logic                s_ar_ready,
  input  logic [ADDR_W-1:0]   s_ar_addr,
  input  logic [ID_W-1:0]     s_ar_id,
  input  logic [7:0]          s_ar_len,
  input  logic [2:0]          s_ar_size,
  input  logic [1:0]          s_ar_burst,
  input  logic [3:0]          s_ar_cache,
  input  logic                s_ar_lock,
  input  logic [2:0]          s_ar_prot,
  input  logic [3:0]          s_ar_qos,
  output logic                s_r_valid,
  input  logic                s_r_ready,
  output logic [DATA_W-1:0]   s_r_data,
  output logic [ID_W-1:0]     s_r_id,
  output logic [1:0]          s_r_resp,
  output logic                s_r_last,
  input  logic                s_aw_valid,
  output logic                s_aw_ready,
  input  logic [ADDR_W-1:0]   s_aw_addr,
  input  logic [ID_W-1:0]     s_aw_id,
  input  logic [7:0]          s_aw_len,
  input  logic [2:0]          s_aw_size,
  input  logic [1:0]          s_aw_burst,
  input  logic [3:0]          s_aw_cache,
  input  logic                s_aw_lock,
  input  logic [2:0]          s_aw_prot,
  input  logic [3:0]          s_aw_qos,
  input  logic                s_w_valid,
  output logic                s_w_ready,
  input  logic [DATA_W-1:0]   s_w_data,
  input  logic [DATA_W/8-1:0] s_w_strb,
  input  logic                s_w_last,
  output logic                s_b_valid,
  input  logic                s_b_ready,
  output logic [ID_W-1:0]     s_b_id,
  output logic [1:0]          s_b_resp,
  output logic                m_ar_valid,
  input  logic                m_ar_ready,
  output logic [ADDR_W-1:0]   m_ar_addr,
  output logic [ID_W-1:0]     m_ar_id,
  output logic [7:0]          m_ar_len,
  output logic [2:0]          m_ar_size,
  output logic [1:0]          m_ar_burst,
  output logic [3:0]          m_ar_cache,
  output logic                m_ar_lock,
  output logic [2:0]          m_ar_prot,
  output logic [3:0]          m_ar_qos,
  input  logic                m_r_valid,
  output logic                m_r_ready,
  input  logic [DATA_W-1:0]   m_r_data,
  input  logic [ID_W-1:0]     m_r_id,
  input  logic [1:0]          m_r_resp,
  input  logic                m_r_last,
  output logic                m_aw_valid,
  input  logic                m_aw_ready,
  output logic [ADDR_W-1:0]   m_aw_addr,
  output logic [ID_W-1:0]     m_aw_id,
  output logic [7:0]          m_aw_len,
  output logic [2:0]          m_aw_size,
  output logic [1:0]          m_aw_burst,
  output logic [3:0]          m_aw_cache,
  output logic                m_aw_lock,
  output logic [2:0]          m_aw_prot,
  output logic [3:0]          m_aw_qos,
  output logic                m_w_valid,
  input  logic                m_w_ready,
  output logic [DATA_W-1:0]   m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb,
  output logic                m_w_last,
  input  logic                m_b_valid,
  output logic                m_b_ready,
  input  logic [ID_W-1:0]     m_b_id,
  input  logic [1:0]          m_b_resp
);

  localparam int CW = $clog2(MAX_OUTST + 1);

  rd_state_t rd_st, rd_nxt;
  wr_state_t wr_st, wr_nxt;
  logic [ID_W-1:0] err_rid, err_wid;
  logic [7:0]      err_len, err_beat;
  logic            rd_rej, wr_rej, ar_hit, aw_hit;
  logic [CW-1:0]   rd_cnt, wr_cnt;
  logic            rd_full, rd_empty, wr_full, wr_empty;
  logic            unused_cnt;

  assign ar_hit = win_hit(64'(s_ar_addr), 64'(IN_BASE), WIN_BITS, ADDR_W);
  assign aw_hit = win_hit(64'(s_aw_addr), 64'(IN_BASE), WIN_BITS, ADDR_W);

  // Address channel payloads pass straight through; only the address is rebased.
  assign m_ar_addr  = ADDR_W'(win_remap(64'(s_ar_addr), 64'(WIN_BASE), WIN_BITS));
  assign m_ar_id    = s_ar_id;
  assign m_ar_len   = s_ar_len;
  assign m_ar_size  = s_ar_size;
  assign m_ar_burst = s_ar_burst;
  assign m_ar_cache = s_ar_cache;
  assign m_ar_lock  = s_ar_lock;
  assign m_ar_prot  = s_ar_prot;
  assign m_ar_qos   = s_ar_qos;
  assign m_aw_addr  = ADDR_W'(win_remap(64'(s_aw_addr), 64'(WIN_BASE), WIN_BITS));
  assign m_aw_id    = s_aw_id;
  assign m_aw_len   = s_aw_len;
  assign m_aw_size  = s_aw_size;
  assign m_aw_burst = s_aw_burst;
  assign m_aw_cache = s_aw_cache;
  assign m_aw_lock  = s_aw_lock;
  assign m_aw_prot  = s_aw_prot;
  assign m_aw_qos   = s_aw_qos;
  assign m_w_data   = s_w_data;
  assign m_w_strb   = s_w_strb;
  assign m_w_last   = s_w_last;

  axi_win_outst_ctr #(.MAX_OUTST(MAX_OUTST)) u_rd_ctr (
    .clock(clock), .reset(reset),
    .inc(m_ar_valid && m_ar_ready), .dec(m_r_valid && m_r_ready && m_r_last),
    .count(rd_cnt), .full(rd_full), .empty(rd_empty)
  );

  axi_win_outst_ctr #(.MAX_OUTST(MAX_OUTST)) u_wr_ctr (
    .clock(clock), .reset(reset),
    .inc(m_aw_valid && m_aw_ready), .dec(m_b_valid && m_b_ready),
    .count(wr_cnt), .full(wr_full), .empty(wr_empty)
  );

  // Raw counts are kept as named nets for debug probing only.
  assign unused_cnt = ^{rd_cnt, wr_cnt};

  // Read path. All handshake outputs are forced low while reset is asserted.
  always_comb begin
    rd_nxt     = rd_st;
    rd_rej     = 1'b0;
    s_ar_ready = 1'b0;
    m_ar_valid = 1'b0;
    s_r_valid  = 1'b0;
    s_r_data   = '0;
    s_r_id     = '0;
    s_r_resp   = RESP_OKAY;
    s_r_last   = 1'b0;
    m_r_ready  = 1'b0;
    if (!reset) begin
      unique case (rd_st)
        R_IDLE, R_WAIT: begin
          s_r_valid = m_r_valid;
          s_r_data  = m_r_data;
          s_r_id    = m_r_id;
          s_r_resp  = m_r_resp;
          s_r_last  = m_r_last;
          m_r_ready = s_r_ready;
          if (rd_st == R_IDLE) begin
            if (s_ar_valid && ar_hit) begin
              m_ar_valid = !rd_full;
              s_ar_ready = m_ar_ready && !rd_full;
            end else if (s_ar_valid) begin
              s_ar_ready = 1'b1;
              rd_rej     = 1'b1;
              rd_nxt     = R_WAIT;
            end
          end else if (rd_empty) begin
            // Downstream fully drained: error beats can no longer interleave.
            rd_nxt = R_ERR;
          end
        end
        R_ERR: begin
          s_r_valid = 1'b1;
          s_r_id    = err_rid;
          s_r_resp  = RESP_DECERR;
          s_r_last  = (err_beat == err_len);
          if (s_r_ready && s_r_last) rd_nxt = R_IDLE;
        end
        default: rd_nxt = R_IDLE;
      endcase
    end
  end

  // Write path. W is only accepted after its AW has been decided.
  always_comb begin
    wr_nxt     = wr_st;
    wr_rej     = 1'b0;
    s_aw_ready = 1'b0;
    m_aw_valid = 1'b0;
    s_w_ready  = 1'b0;
    m_w_valid  = 1'b0;
    s_b_valid  = 1'b0;
    s_b_id     = '0;
    s_b_resp   = RESP_OKAY;
    m_b_ready  = 1'b0;
    if (!reset) begin
      if (wr_st != W_ERRB) begin
        s_b_valid = m_b_valid;
        s_b_id    = m_b_id;
        s_b_resp  = m_b_resp;
        m_b_ready = s_b_ready;
      end
      unique case (wr_st)
        W_IDLE: begin
          if (s_aw_valid && aw_hit) begin
            m_aw_valid = !wr_full;
            s_aw_ready = m_aw_ready && !wr_full;
            if (s_aw_ready) wr_nxt = W_PASS;
          end else if (s_aw_valid) begin
            s_aw_ready = 1'b1;
            wr_rej     = 1'b1;
            wr_nxt     = W_DRAIN;
          end
        end
        W_PASS: begin
          m_w_valid = s_w_valid;
          s_w_ready = m_w_ready;
          if (s_w_valid && m_w_ready && s_w_last) wr_nxt = W_IDLE;
        end
        W_DRAIN: begin
          s_w_ready = 1'b1;
          if (s_w_valid && s_w_last) wr_nxt = W_ERRB;
        end
        W_ERRB: begin
          s_b_valid = wr_empty;
          s_b_id    = err_wid;
          s_b_resp  = RESP_DECERR;
          if (s_b_valid && s_b_ready) wr_nxt = W_IDLE;
        end
        default: wr_nxt = W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_st    <= R_IDLE;
      wr_st    <= W_IDLE;
      err_rid  <= '0;
      err_wid  <= '0;
      err_len  <= '0;
      err_beat <= '0;
    end else begin
      rd_st <= rd_nxt;
      wr_st <= wr_nxt;
      if (rd_rej) begin
        err_rid  <= s_ar_id;
        err_len  <= s_ar_len;
        err_beat <= '0;
      end else if (rd_st == R_ERR && s_r_ready) begin
        err_beat <= err_beat + 1'b1;
      end
      if (wr_rej) err_wid <= s_aw_id;
    end
  end

`ifdef AXI_WIN_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      err_rd_cnt    <= '0;
      err_wr_cnt    <= '0;
      last_err_addr <= '0;
    end else begin
      if (rd_rej && err_rd_cnt != '1) err_rd_cnt <= err_rd_cnt + 1'b1;
      if (wr_rej && err_wr_cnt != '1) err_wr_cnt <= err_wr_cnt + 1'b1;
      // AR wins when both directions reject in the same cycle.
      if (rd_rej)      last_err_addr <= s_ar_addr;
      else if (wr_rej) last_err_addr <= s_aw_addr;
    end
  end
`endif

endmodule

// File: tb/tb_axi_mem_window.sv
// Self-checking bench for axi_mem_window (MAX_OUTST = 2) with a queue-based reference model.
// Ports: none; drives every DUT port, models a simple downstream slave inline.
// Checks reset state, remap, DECERR reads/writes, ordering, back-pressure and reset mid-burst.
module tb_axi_mem_window;

  typedef struct packed {logic [5:0] id; logic [7:0] len;} burst_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic s_ar_valid, s_ar_ready, s_ar_lock, s_aw_valid, s_aw_ready, s_aw_lock;
  logic [31:0] s_ar_addr, s_aw_addr, m_ar_addr, m_aw_addr;
  logic [5:0]  s_ar_id, s_aw_id, m_ar_id, m_aw_id, s_r_id, m_r_id, s_b_id, m_b_id;
  logic [7:0]  s_ar_len, s_aw_len, m_ar_len, m_aw_len;
  logic [2:0]  s_ar_size, s_aw_size, m_ar_size, m_aw_size, s_ar_prot, s_aw_prot, m_ar_prot, m_aw_prot;
  logic [1:0]  s_ar_burst, s_aw_burst, m_ar_burst, m_aw_burst;
  logic [3:0]  s_ar_cache, s_aw_cache, m_ar_cache, m_aw_cache, s_ar_qos, s_aw_qos, m_ar_qos, m_aw_qos;
  logic        m_ar_lock, m_aw_lock, m_ar_valid, m_ar_ready, m_aw_valid, m_aw_ready;
  logic        s_r_valid, s_r_ready, s_r_last, m_r_valid, m_r_ready, m_r_last;
  logic [63:0] s_r_data, m_r_data, s_w_data, m_w_data;
  logic [1:0]  s_r_resp, m_r_resp, s_b_resp, m_b_resp;
  logic        s_w_valid, s_w_ready, s_w_last, m_w_valid, m_w_ready, m_w_last;
  logic [7:0]  s_w_strb, m_w_strb;
  logic        s_b_valid, s_b_ready, m_b_valid, m_b_ready;
`ifdef AXI_WIN_STATS_EN
  logic [31:0] err_rd_cnt, err_wr_cnt, last_err_addr;
`endif

  axi_mem_window #(.MAX_OUTST(2)) dut (
`ifdef AXI_WIN_STATS_EN
    .err_rd_cnt(err_rd_cnt), .err_wr_cnt(err_wr_cnt), .last_err_addr(last_err_addr),
`endif
    .clock(clock), .reset(reset),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_id(s_ar_id),
    .s_ar_len(s_ar_len), .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_cache(s_ar_cache),
    .s_ar_lock(s_ar_lock), .s_ar_prot(s_ar_prot), .s_ar_qos(s_ar_qos),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_id(s_r_id),
    .s_r_resp(s_r_resp), .s_r_last(s_r_last),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_id(s_aw_id),
    .s_aw_len(s_aw_len), .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_cache(s_aw_cache),
    .s_aw_lock(s_aw_lock), .s_aw_prot(s_aw_prot), .s_aw_qos(s_aw_qos),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_w_last(s_w_last),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_id(m_ar_id),
    .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst), .m_ar_cache(m_ar_cache),
    .m_ar_lock(m_ar_lock), .m_ar_prot(m_ar_prot), .m_ar_qos(m_ar_qos),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_id(m_r_id),
    .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_id(m_aw_id),
    .m_aw_len(m_aw_len), .m_aw_size(m_aw_size), .m_aw_burst(m_aw_burst), .m_aw_cache(m_aw_cache),
    .m_aw_lock(m_aw_lock), .m_aw_prot(m_aw_prot), .m_aw_qos(m_aw_qos),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_w_last(m_w_last),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id), .m_b_resp(m_b_resp)
  );

  int checks = 0;
  int errors = 0;
  burst_t rdq[$];
  int unsigned n_rd_err = 0;
  int unsigned n_wr_err = 0;
  logic [31:0] last_rej = 32'h0;

  // Reference model: 256 MB window at 0, rebased to 0x1000_0000.
  function automatic logic model_hit(input logic [31:0] a);
    return a < 32'h1000_0000;
  endfunction
  function automatic logic [31:0] model_remap(input logic [31:0] a);
    return 32'h1000_0000 + (a % 32'h1000_0000);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow #1 later.
  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic ar_send(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    burst_t b;
    logic [3:0] cache, qos;
    logic [2:0] prot;
    int k;
    cache = 4'($urandom); qos = 4'($urandom); prot = 3'($urandom);
    s_ar_valid = 1'b1; s_ar_addr = a; s_ar_id = id; s_ar_len = len; s_ar_size = 3'd3;
    s_ar_burst = 2'b01; s_ar_cache = cache; s_ar_lock = 1'b0; s_ar_prot = prot; s_ar_qos = qos;
    #1;
    k = 0;
    while (k < 20 && !s_ar_ready) begin cyc(); k++; end
    chk("ar_ready", 64'(s_ar_ready), 64'd1);
    if (model_hit(a)) begin
      chk("ar_fwd_valid", 64'(m_ar_valid), 64'd1);
      chk("ar_remap", 64'(m_ar_addr), 64'(model_remap(a)));
      chk("ar_fields", 64'({m_ar_id, m_ar_len, m_ar_size, m_ar_burst, m_ar_cache, m_ar_lock, m_ar_prot, m_ar_qos}),
          64'({id, len, 3'd3, 2'b01, cache, 1'b0, prot, qos}));
      b.id = id; b.len = len;
      rdq.push_back(b);
    end else begin
      chk("ar_blocked_fwd", 64'(m_ar_valid), 64'd0);
      n_rd_err++;
      last_rej = a;
    end
    cyc();
    s_ar_valid = 1'b0;
  endtask

  // Downstream returns the oldest in-window read; bench expects it unchanged upstream.
  task automatic ds_burst();
    burst_t b;
    logic [63:0] d;
    b = rdq.pop_front();
    for (int i = 0; i <= int'(b.len); i++) begin
      d = {$urandom, $urandom};
      m_r_valid = 1'b1; m_r_data = d; m_r_id = b.id; m_r_resp = 2'b00;
      m_r_last = (i == int'(b.len)); s_r_ready = 1'b1;
      #1;
      chk("r_pass_valid", 64'(s_r_valid), 64'd1);
      chk("r_pass_data", s_r_data, d);
      chk("r_pass_id_resp_last", 64'({s_r_id, s_r_resp, s_r_last, m_r_ready}),
          64'({b.id, 2'b00, (i == int'(b.len)), 1'b1}));
      cyc();
    end
    m_r_valid = 1'b0; m_r_last = 1'b0;
  endtask

  task automatic err_burst(input logic [5:0] id, input logic [7:0] len);
    int k;
    s_r_ready = 1'b1;
    #1;
    k = 0;
    while (k < 20 && !s_r_valid) begin cyc(); k++; end
    chk("err_r_timeout", 64'(s_r_valid), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      chk("err_r_data", s_r_data, 64'd0);
      chk("err_r_id_resp_last", 64'({s_r_valid, s_r_id, s_r_resp, s_r_last, m_r_ready}),
          64'({1'b1, id, 2'b11, (i == int'(len)), 1'b0}));
      cyc();
    end
    chk("err_r_done", 64'(s_r_valid), 64'd0);
  endtask

  task automatic aw_send(input logic [31:0] a, input logic [5:0] id, input logic [7:0] len);
    logic [3:0] cache, qos;
    logic [2:0] prot;
    int k;
    cache = 4'($urandom); qos = 4'($urandom); prot = 3'($urandom);
    s_aw_valid = 1'b1; s_aw_addr = a; s_aw_id = id; s_aw_len = len; s_aw_size = 3'd3;
    s_aw_burst = 2'b01; s_aw_cache = cache; s_aw_lock = 1'b1; s_aw_prot = prot; s_aw_qos = qos;
    #1;
    k = 0;
    while (k < 20 && !s_aw_ready) begin cyc(); k++; end
    chk("aw_ready", 64'(s_aw_ready), 64'd1);
    if (model_hit(a)) begin
      chk("aw_fwd_valid", 64'(m_aw_valid), 64'd1);
      chk("aw_remap", 64'(m_aw_addr), 64'(model_remap(a)));
      chk("aw_fields", 64'({m_aw_id, m_aw_len, m_aw_size, m_aw_burst, m_aw_cache, m_aw_lock, m_aw_prot, m_aw_qos}),
          64'({id, len, 3'd3, 2'b01, cache, 1'b1, prot, qos}));
    end else begin
      chk("aw_blocked_fwd", 64'(m_aw_valid), 64'd0);
      n_wr_err++;
      last_rej = a;
    end
    cyc();
    s_aw_valid = 1'b0;
  endtask

  task automatic w_beats(input logic [7:0] len, input logic fwd);
    logic [63:0] d;
    logic [7:0] st;
    for (int i = 0; i <= int'(len); i++) begin
      d = {$urandom, $urandom}; st = 8'($urandom);
      s_w_valid = 1'b1; s_w_data = d; s_w_strb = st; s_w_last = (i == int'(len));
      #1;
      chk("w_ready", 64'(s_w_ready), 64'd1);
      chk("w_fwd_valid", 64'(m_w_valid), 64'(fwd));
      if (fwd) begin
        chk("w_data", m_w_data, d);
        chk("w_strb_last", 64'({m_w_strb, m_w_last}), 64'({st, (i == int'(len))}));
      end
      cyc();
    end
    s_w_valid = 1'b0; s_w_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [5:0]  id;
    logic [7:0]  len;
    int k;

    {s_ar_valid, s_ar_addr, s_ar_id, s_ar_len, s_ar_size, s_ar_burst, s_ar_cache, s_ar_lock, s_ar_prot, s_ar_qos} = '0;
    {s_aw_valid, s_aw_addr, s_aw_id, s_aw_len, s_aw_size, s_aw_burst, s_aw_cache, s_aw_lock, s_aw_prot, s_aw_qos} = '0;
    {s_r_ready, s_w_valid, s_w_data, s_w_strb, s_w_last, s_b_ready} = '0;
    {m_ar_ready, m_r_valid, m_r_data, m_r_id, m_r_resp, m_r_last} = '0;
    {m_aw_ready, m_w_ready, m_b_valid, m_b_id, m_b_resp} = '0;

    // Reset: every valid/ready output low even with all inputs active.
    cyc(); cyc();
    s_ar_valid = 1'b1; s_ar_addr = 32'h0000_1000; m_ar_ready = 1'b1; m_r_valid = 1'b1; s_r_ready = 1'b1;
    s_aw_valid = 1'b1; s_aw_addr = 32'h0000_2000; m_aw_ready = 1'b1; s_w_valid = 1'b1; m_w_ready = 1'b1;
    m_b_valid = 1'b1; s_b_ready = 1'b1;
    #1;
    chk("rst_s_ready", 64'({s_ar_ready, s_aw_ready, s_w_ready, s_r_valid, s_b_valid}), 64'd0);
    chk("rst_m_ready", 64'({m_ar_valid, m_aw_valid, m_w_valid, m_r_ready, m_b_ready}), 64'd0);
`ifdef AXI_WIN_STATS_EN
    chk("rst_stats", {err_rd_cnt, err_wr_cnt} | 64'(last_err_addr), 64'd0);
`endif
    {s_ar_valid, m_r_valid, s_r_ready, s_aw_valid, s_w_valid, m_b_valid, s_b_ready} = '0;
    cyc();
    reset = 1'b0;
    cyc();

    // In-window read at 0x1000, 4 beats.
    ar_send(32'h0000_1000, 6'($urandom), 8'd3);
    ds_burst();

    // Out-of-window read: 2 DECERR beats, id 5.
    ar_send(32'h2000_0040, 6'd5, 8'd1);
    err_burst(6'd5, 8'd1);

    // Two outstanding reads fill MAX_OUTST=2; a third waits for one last beat.
    ar_send(32'h0000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF)), 6'd1, 8'($urandom_range(0, 2)));
    ar_send(32'h0ABC_0000, 6'd2, 8'($urandom_range(0, 2)));
    s_ar_valid = 1'b1; s_ar_addr = 32'h0123_4000; s_ar_id = 6'd3; s_ar_len = 8'd1;
    #1;
    chk("full_ar_ready", 64'({s_ar_ready, m_ar_valid}), 64'd0);
    cyc();
    chk("full_ar_ready_hold", 64'(s_ar_ready), 64'd0);
    ds_burst();
    s_ar_valid = 1'b0;
    ar_send(32'h0123_4000, 6'd3, 8'd1);
    ar_send(32'hF000_0100, 6'd9, 8'd2);
    cyc(); cyc();
    chk("no_interleave_2", 64'(s_r_valid), 64'd0);
    ds_burst();
    cyc();
    chk("no_interleave_1", 64'(s_r_valid), 64'd0);
    ds_burst();
    err_burst(6'd9, 8'd2);

    // Randomized reads against the window model.
    for (int n = 0; n < 8; n++) begin
      a = $urandom;
      if (n % 2 == 0) a = a & 32'h0FFF_FFFF;
      id = 6'($urandom); len = 8'($urandom_range(0, 3));
      ar_send(a, id, len);
      if (model_hit(a)) ds_burst();
      else err_burst(id, len);
    end

    // Out-of-window write: 8 beats sunk, then DECERR B.
    m_w_ready = 1'b1; m_aw_ready = 1'b1;
    id = 6'($urandom);
    aw_send(32'h3000_0000 | 32'($urandom_range(0, 4095)), id, 8'd7);
    w_beats(8'd7, 1'b0);
    s_b_ready = 1'b0;
    #1;
    k = 0;
    while (k < 20 && !s_b_valid) begin cyc(); k++; end
    chk("errb_timeout", 64'(s_b_valid), 64'd1);
    chk("errb_fields", 64'({s_b_id, s_b_resp, m_b_ready}), 64'({id, 2'b11, 1'b0}));
    s_b_ready = 1'b1;
    cyc();
    s_b_ready = 1'b0;
    #1;
    chk("errb_done", 64'(s_b_valid), 64'd0);

    // In-window write: W arriving early is held until AW passes.
    s_w_valid = 1'b1; s_w_last = 1'b0;
    #1;
    chk("w_held", 64'({s_w_ready, m_w_valid}), 64'd0);
    s_w_valid = 1'b0;
    id = 6'($urandom); len = 8'($urandom_range(0, 3));
    aw_send(32'h0000_0000 | 32'($urandom_range(0, 32'h0FFF_FFFF)), id, len);
    w_beats(len, 1'b1);
    m_b_valid = 1'b1; m_b_id = id; m_b_resp = 2'b10; s_b_ready = 1'b1;
    #1;
    chk("b_pass", 64'({s_b_valid, s_b_id, s_b_resp, m_b_ready}), 64'({1'b1, id, 2'b10, 1'b1}));
    cyc();
    m_b_valid = 1'b0; s_b_ready = 1'b0;

`ifdef AXI_WIN_STATS_EN
    #1;
    chk("stat_rd", 64'(err_rd_cnt), 64'(n_rd_err));
    chk("stat_wr", 64'(err_wr_cnt), 64'(n_wr_err));
    chk("stat_addr", 64'(last_err_addr), 64'(last_rej));
`endif

    // Reset on the 2nd of 4 error beats abandons the burst.
    ar_send(32'h4000_0000 | 32'($urandom_range(0, 4095)), 6'd7, 8'd3);
    s_r_ready = 1'b1;
    #1;
    k = 0;
    while (k < 20 && !s_r_valid) begin cyc(); k++; end
    chk("rst_err_timeout", 64'(s_r_valid), 64'd1);
    cyc();
    chk("rst_err_beat2", 64'({s_r_valid, s_r_resp, s_r_last}), 64'({1'b1, 2'b11, 1'b0}));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(s_r_valid), 64'd0);
    cyc();
    chk("rst_after_idle", 64'({s_r_valid, s_ar_ready, s_b_valid}), 64'd0);
`ifdef AXI_WIN_STATS_EN
    chk("rst_mid_stats", {err_rd_cnt, err_wr_cnt} | 64'(last_err_addr), 64'd0);
`endif
    ar_send(32'h0000_4000, 6'd4, 8'd0);
    ds_burst();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
